// File: rtl/rxuartlite_sfr.sv
// 8N1 UART receiver for the r8051 SFR bus: mid-bit sampling, start/stop
// validation, small receive FIFO and registered status/data reads.
module rxuartlite_sfr #(
  parameter int CLOCKS_PER_BAUD = 347,
  parameter int TIMING_BITS     = 10,
  parameter int FIFO_AW         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  input  logic       i_rd_en,
  input  logic       i_rd_addr,
  output logic [7:0] o_rd_byte,
  output logic       o_rx_avail,
  output logic       o_busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [TIMING_BITS-1:0] HALF_LOAD = TIMING_BITS'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [TIMING_BITS-1:0] FULL_LOAD = TIMING_BITS'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state, state_nx;
  logic                   rx_meta, rxs;
  logic [TIMING_BITS-1:0] cnt, cnt_nx;
  logic [2:0]             idx, idx_nx;
  logic [7:0]             shreg, shreg_nx;
  logic                   push_req, stop_bad;

  logic [7:0]             mem [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
  logic [FIFO_AW:0]       count;
  logic                   full, pop, push, ovr_evt, clr;
  logic                   overrun, frame_err;
  logic [7:0]             status;

  // Synchronizer presets high so reset release never looks like a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    push_req = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nx = START;
          cnt_nx   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt != '0) cnt_nx = cnt - TIMING_BITS'(1);
        else if (rxs) state_nx = IDLE;
        else begin
          state_nx = DATA;
          idx_nx   = '0;
          cnt_nx   = FULL_LOAD;
        end
      end
      DATA: begin
        if (cnt != '0) cnt_nx = cnt - TIMING_BITS'(1);
        else begin
          shreg_nx[idx] = rxs;
          cnt_nx        = FULL_LOAD;
          idx_nx        = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) cnt_nx = cnt - TIMING_BITS'(1);
        else if (rxs) begin
          push_req = 1'b1;
          state_nx = IDLE;
        end else begin
          stop_bad = 1'b1;
          state_nx = BREAK;
        end
      end
      BREAK: if (rxs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign pop     = i_rd_en & i_rd_addr & (count != '0);
  assign push    = push_req & (~full | pop);
  assign ovr_evt = push_req & full & ~pop;
  assign clr     = i_rd_en & ~i_rd_addr;

  assign o_rx_avail = (count != '0);
  assign o_busy     = (state != IDLE);
  assign status     = {4'b0000, frame_err, overrun, full, o_rx_avail};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      o_rd_byte <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      // Error events win over a same-cycle status-read clear
      overrun   <= (overrun & ~clr) | ovr_evt;
      frame_err <= (frame_err & ~clr) | stop_bad;
      if (i_rd_en) o_rd_byte <= i_rd_addr ? (pop ? mem[rd_ptr] : 8'h00) : status;
    end
  end

endmodule

// File: tb/tb_rxuartlite_sfr.sv
// Self-checking bench for rxuartlite_sfr: directed scenarios plus random
// frames, checked against a queue-based model of the receiver.
module tb_rxuartlite_sfr;

  localparam int CPB   = 347;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       rd_en;
  logic       rd_addr;
  logic [7:0] rd_byte;
  logic       rx_avail;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_ferr;

  rxuartlite_sfr #(
    .CLOCKS_PER_BAUD(CPB),
    .TIMING_BITS    (10),
    .FIFO_AW        (2)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .i_uart_rx (uart_rx),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_byte (rd_byte),
    .o_rx_avail(rx_avail),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Model effect of one SFR read; returns the byte the CPU should see
  function automatic logic [7:0] model_read(input logic addr);
    logic [7:0] v;
    if (!addr) begin
      v = {4'b0000, m_ferr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else if (mq.size() != 0) v = mq.pop_front();
    else v = 8'h00;
    return v;
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic sfr_read(input logic addr, output logic [7:0] val);
    rd_en   = 1'b1;
    rd_addr = addr;
    @(negedge clk);
    rd_en = 1'b0;
    val   = rd_byte;
  endtask

  task automatic rd_model(input logic addr, input string tag);
    logic [7:0] exp, got;
    check({tag, "_avail"}, {7'b0, rx_avail}, {7'b0, mq.size() != 0});
    exp = model_read(addr);
    sfr_read(addr, got);
    check(tag, got, exp);
  endtask

  task automatic rd_expect(input logic addr, input logic [7:0] exp, input string tag);
    logic [7:0] got, unused;
    unused = model_read(addr);
    sfr_read(addr, got);
    check(tag, got, exp);
  endtask

  task automatic drive_bits(input logic v, input int nbits);
    uart_rx = v;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good, input int extra_low);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
    if (good) drive_bits(1'b1, 1);
    else begin
      drive_bits(1'b0, 1 + extra_low);
      uart_rx = 1'b1;
    end
    model_frame(b, good);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [7:0] b;
    logic good;

    rst_n   = 1'b0;
    uart_rx = 1'b1;
    rd_en   = 1'b0;
    rd_addr = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_rd_byte", rd_byte, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_avail", {7'b0, rx_avail}, 8'h00);
    rst_n = 1'b1;

    idle(10000);
    check("idle_busy", {7'b0, busy}, 8'h00);
    rd_expect(1'b0, 8'h00, "idle_status");
    rd_expect(1'b1, 8'h00, "idle_data");

    // 0x55 with avail-latency measurement from the start edge
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        while (!rx_avail && lat < 4000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("avail_latency_ok", {7'b0, (lat >= 3290 && lat <= 3306)}, 8'h01);
    idle(20);
    rd_expect(1'b0, 8'h01, "s55_status");
    rd_expect(1'b1, 8'h55, "s55_data");
    rd_expect(1'b0, 8'h00, "s55_status2");

    // 100-clk glitch
    uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy", {7'b0, busy}, 8'h01);
    repeat (50) @(negedge clk);
    uart_rx = 1'b1;
    repeat (76) @(negedge clk);
    check("glitch_idle", {7'b0, busy}, 8'h00);
    rd_model(1'b0, "glitch_status");

    // bad stop followed by long break
    send_frame(8'hA3, 1'b0, 20);
    idle(CPB);
    check("break_idle", {7'b0, busy}, 8'h00);
    rd_expect(1'b0, 8'h08, "brk_status");
    rd_expect(1'b0, 8'h00, "brk_status2");
    send_frame(8'h3C, 1'b1, 0);
    idle(10);
    rd_expect(1'b1, 8'h3C, "after_brk_data");

    // overrun: five back-to-back frames
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0);
      if (i == 4) rd_expect(1'b0, 8'h03, "ovr_status4");
      if (i == 5) rd_expect(1'b0, 8'h07, "ovr_status5");
    end
    idle(10);
    rd_expect(1'b1, 8'h01, "ovr_d1");
    rd_expect(1'b1, 8'h02, "ovr_d2");
    rd_expect(1'b1, 8'h03, "ovr_d3");
    rd_expect(1'b1, 8'h04, "ovr_d4");
    rd_expect(1'b1, 8'h00, "ovr_d5");
    rd_expect(1'b0, 8'h00, "ovr_status_clr");

    // reset mid-frame during bit 3 of 0xFF
    drive_bits(1'b0, 1);
    drive_bits(1'b1, 3);
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("midrst_busy", {7'b0, busy}, 8'h00);
    check("midrst_rd_byte", rd_byte, 8'h00);
    rst_n = 1'b1;
    idle(6 * CPB);
    send_frame(8'h81, 1'b1, 0);
    idle(10);
    rd_expect(1'b0, 8'h01, "midrst_status");
    rd_expect(1'b1, 8'h81, "midrst_data");
    rd_expect(1'b0, 8'h00, "midrst_status2");

    // random frames with interleaved random reads
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(3) != 0);
      send_frame(b, good, int'($urandom_range(3)));
      idle(int'($urandom_range(300, 10)));
      check("rnd_busy", {7'b0, busy}, 8'h00);
      for (int k = 0; k < int'($urandom_range(3)); k++)
        rd_model(1'($urandom), "rnd_read");
    end
    rd_model(1'b0, "drain_status");
    while (mq.size() != 0) rd_model(1'b1, "drain_data");
    rd_model(1'b1, "drain_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
